// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and helpers for reg_file_mp (types do not depend on REG_FILE_PARITY_EN)
package reg_file_pkg;
  localparam int MAX_W = 1024;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;
  typedef logic [MAX_W-1:0] word_t;
  typedef logic [MAX_W/8-1:0] be_t;
  // Helpers work on the widest word; callers zero-extend in and truncate out.
  function automatic word_t be_merge(word_t old, word_t data, be_t be);
    word_t r;
    for (int i = 0; i < MAX_W/8; i++) r[8*i +: 8] = be[i] ? data[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
  function automatic logic parity(word_t w);
    return ^w;
  endfunction
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one registered read port with range check and write bypass
// Optional parity checking with REG_FILE_PARITY_EN.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] entry_i,
`ifdef REG_FILE_PARITY_EN
  input  logic              entry_par_i,
  output logic              perr_o,
`endif
  input  logic              byp_en_i,
  input  logic [ADDR_W-1:0] byp_addr_i,
  input  logic [DATA_W-1:0] byp_data_i,
  input  logic [DATA_W/8-1:0] byp_be_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);
  logic in_range, byp;
  logic [DATA_W-1:0] merged;
  always_comb begin
    in_range = 32'(addr_i) < DEPTH;
    byp = byp_en_i && byp_addr_i == addr_i;
    merged = DATA_W'(be_merge(word_t'(entry_i), word_t'(byp_data_i), be_t'(byp_be_i)));
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      data_o <= '0;
      valid_o <= 1'b0;
`ifdef REG_FILE_PARITY_EN
      perr_o <= 1'b0;
`endif
    end else begin
      valid_o <= en_i;
      if (en_i) data_o <= !in_range ? '0 : byp ? merged : entry_i;
`ifdef REG_FILE_PARITY_EN
      perr_o <= en_i && in_range && !byp && parity(word_t'(entry_i)) != entry_par_i;
`endif
    end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with byte enables, bypass and bulk clear
// Optional per-entry even parity and rd_perr_o with REG_FILE_PARITY_EN.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 16,
  parameter int NUM_RD = 2,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W = DATA_W/8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [BE_W-1:0]          wr_be_i,
  output logic                     wr_drop_o,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_valid_o,
`ifdef REG_FILE_PARITY_EN
  output logic [NUM_RD-1:0]        rd_perr_o,
`endif
  input  logic                     clr_req_i,
  output logic                     clr_busy_o,
  output logic                     clr_done_o
);
  clr_state_t state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef REG_FILE_PARITY_EN
  logic [DEPTH-1:0] par;
`endif
  logic wr_in, we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data, w_word;
  logic [BE_W-1:0] w_be;
  // A clear cycle is just a full-width write of zero to the pointer entry.
  always_comb begin
    wr_in = 32'(wr_addr_i) < DEPTH;
    we = (state == IDLE && wr_en_i && wr_in) || state == CLEAR;
    w_addr = state == CLEAR ? ptr : wr_addr_i;
    w_data = state == CLEAR ? '0 : wr_data_i;
    w_be = state == CLEAR ? '1 : wr_be_i;
    w_word = DATA_W'(be_merge(word_t'(mem[w_addr]), word_t'(w_data), be_t'(w_be)));
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef REG_FILE_PARITY_EN
      par <= '0;
`endif
    end else if (we) begin
      mem[w_addr] <= w_word;
`ifdef REG_FILE_PARITY_EN
      par[w_addr] <= parity(word_t'(w_word));
`endif
    end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state <= IDLE;
      ptr <= '0;
      clr_busy_o <= 1'b0;
      clr_done_o <= 1'b0;
      wr_drop_o <= 1'b0;
    end else begin
      wr_drop_o <= wr_en_i && (!wr_in || state == CLEAR);
      clr_done_o <= 1'b0;
      case (state)
        IDLE: if (clr_req_i) begin
          state <= CLEAR;
          ptr <= '0;
          clr_busy_o <= 1'b1;
        end
        CLEAR: if (32'(ptr) == DEPTH-1) begin
          state <= DONE;
          ptr <= '0;
          clr_busy_o <= 1'b0;
          clr_done_o <= 1'b1;
        end else ptr <= ptr + 1'b1;
        default: state <= IDLE;
      endcase
    end
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_rd_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rd (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .en_i       (rd_en_i[p]),
      .addr_i     (rd_addr_i[p*ADDR_W +: ADDR_W]),
      .entry_i    (mem[rd_addr_i[p*ADDR_W +: ADDR_W]]),
`ifdef REG_FILE_PARITY_EN
      .entry_par_i(par[rd_addr_i[p*ADDR_W +: ADDR_W]]),
      .perr_o     (rd_perr_o[p]),
`endif
      .byp_en_i   (we),
      .byp_addr_i (w_addr),
      .byp_data_i (w_data),
      .byp_be_i   (w_be),
      .data_o     (rd_data_o[p*DATA_W +: DATA_W]),
      .valid_o    (rd_valid_o[p])
    );
  end
endmodule
